mult_share_arbiter: RTL

- Shares one sequential shift-add unsigned multiplier between NUM_REQ requesters.
- Arbitrates round-robin and captures the winner's operands.
- Sequences the shift/add iterations and returns the product tagged with the requester ID.
- Sits between lab-level operand sources (switch/FSM requesters) and the single multiplier datapath.

---
 rtl/mult_share_pkg.sv | 36 +++
 rtl/mult_share_arbiter_if.sv | 30 +++
 rtl/shift_add_mult_core.sv | 42 ++++
 rtl/mult_share_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared shift-add multiplier arbiter.
// Holds the FSM state enum, the ID width helper and the round-robin search.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Upper bound on requester count supported by rr_first.
  localparam int unsigned MAX_REQ = 32;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // First asserted request at or after ptr, wrapping modulo num_req.
  function automatic int unsigned rr_first(input logic [MAX_REQ-1:0] req,
                                           input int unsigned         ptr,
                                           input int unsigned         num_req);
    int unsigned pick;
    bit          found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (!found && (i < num_req) && req[(ptr + i) % num_req]) begin
        pick  = (ptr + i) % num_req;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bundle of the shared multiplier: requests, operands, grant and result.
// The master modport drives requests/operands; the slave modport is the arbiter.
interface mult_share_arbiter_if
  import mult_share_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*N-1:0] a_in;
  logic [NUM_REQ*N-1:0] b_in;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;
  logic [2*N-1:0]       result_out;

  modport master (
    output req, a_in, b_in,
    input  grant, busy, done, done_id, result_out
  );

  modport slave (
    input  req, a_in, b_in,
    output grant, busy, done, done_id, result_out
  );

endinterface

// File: rtl/shift_add_mult_core.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// Iteration stops by itself once the remaining multiplier is zero.
module shift_add_mult_core #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           zero_b,
  output logic [2*N-1:0] product
);

  logic [2*N-1:0] a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] acc_q;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= {{N{1'b0}}, a};
      b_q   <= b;
      acc_q <= '0;
    end else if (b_q != '0) begin
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
    end
  end

  assign zero_b  = (b_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between NUM_REQ requesters.
// Define MULT_SHARE_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input logic                 clk,
  input logic                 reset,
  mult_share_arbiter_if.slave bus
);

  state_e          state_q;
  state_e          state_d;
  logic [ID_W-1:0] winner_q;
  logic [ID_W-1:0] winner_d;
  logic [ID_W-1:0] ptr_q;
  logic            load;
  logic            zero_b;
  logic [2*N-1:0]  product;
  logic [2*N-1:0]  result_q;
  logic [ID_W-1:0] done_id_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req != '0) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (zero_b) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant = '0;
    load      = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      LOAD: begin
        bus.grant = NUM_REQ'(1) << winner_q;
        load      = 1'b1;
        bus.busy  = 1'b1;
      end
      RUN:  bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULT_SHARE_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (state_q == LOAD) begin
      ptr_q <= (winner_q == ID_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    end
  end
`endif

  assign winner_d = ID_W'(rr_first(MAX_REQ'(bus.req), 32'(ptr_q), NUM_REQ));

  // Winner is frozen once LOAD begins, so req changes during an operation are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner_q <= '0;
    end else if (state_q == IDLE && bus.req != '0) begin
      winner_q <= winner_d;
    end
  end

  shift_add_mult_core #(.N(N)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .a       (bus.a_in[winner_q*N +: N]),
    .b       (bus.b_in[winner_q*N +: N]),
    .zero_b  (zero_b),
    .product (product)
  );

  // Result is captured on entry to DONE and held until the next completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q  <= '0;
      done_id_q <= '0;
    end else if (state_q == RUN && zero_b) begin
      result_q  <= product;
      done_id_q <= winner_q;
    end
  end

  assign bus.result_out = result_q;
  assign bus.done_id    = done_id_q;

endmodule
